// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constants, FSM state encoding and the
// column/byte helpers used by the inverse MixColumns datapath.
package aes_pkg;

    // Reduction term of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0]  AES_POLY     = 8'h1B;
    // First row of the circulant inverse MixColumns matrix.
    localparam logic [31:0] INV_MIX_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};
    localparam int          NUM_COLS     = 4;

    // Controller states, kept as plain constants for legacy compatibility.
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t BUSY = 1'b1;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by a constant: XOR of the xtime powers selected by the
    // constant's bits. With a constant coefficient this folds to a few XORs.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b,
                                                input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = '0;
        pw  = b;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ pw;
            pw = xtime(pw);
        end
        return acc;
    endfunction

    // Extract column c of a row-major state; row 0 lands in the column MSBs.
    function automatic logic [31:0] get_col(input logic [127:0] st,
                                            input logic [1:0]   c);
        logic [31:0] col;
        for (int r = 0; r < 4; r++)
            col[31-8*r -: 8] = st[127-8*(4*r+int'(c)) -: 8];
        return col;
    endfunction

    // Write column c back into its row-major byte positions.
    function automatic logic [127:0] put_col(input logic [127:0] st,
                                             input logic [1:0]   c,
                                             input logic [31:0]  col);
        logic [127:0] res;
        res = st;
        for (int r = 0; r < 4; r++)
            res[127-8*(4*r+int'(c)) -: 8] = col[31-8*r -: 8];
        return res;
    endfunction

endpackage

// File: rtl/inv_calc_column.sv
// Combinational inverse MixColumns of one 32-bit column (row 0 in the MSBs).
module inv_calc_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] s [4];

    // Split the column into its four row bytes.
    always_comb begin
        for (int r = 0; r < 4; r++)
            s[r] = col_in[31-8*r -: 8];
    end

    // Row r = 0e*s[r] ^ 0b*s[r+1] ^ 0d*s[r+2] ^ 09*s[r+3], rows mod 4.
    always_comb begin
        // NOTE: default assignment first so every path writes col_out and no latch is inferred.
        col_out = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                col_out[31-8*r -: 8] = col_out[31-8*r -: 8]
                    ^ gf_mul_const(s[2'(r + j)], INV_MIX_COEF[31-8*j -: 8]);
    end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES inverse MixColumns: COLS_PER_CYCLE columns per clock under a
// start/busy/done handshake. po_out updates only when a transform completes.
module inv_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         pi_clk,
    input  logic         pi_rst_n,
    input  logic         pi_start,
    input  logic [127:0] pi_in,
    output logic         po_busy,
    output logic         po_done,
    output logic [127:0] po_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Index of the first column handled on the completing edge.
    localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

    state_t       state_q;
    logic [1:0]   idx_q;
    logic [127:0] in_q;
    logic [127:0] res_q;
    logic [127:0] res_next;
    logic [127:0] out_q;
    logic         done_q;

    logic [1:0]   col_sel [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    // One column engine per lane; lane g works on column idx+g of the latched input.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_sel[g] = idx_q + 2'(g);
        assign col_in[g]  = get_col(in_q, col_sel[g]);

        inv_calc_column u_calc (
            .col_in  (col_in[g]),
            .col_out (col_out[g])
        );
    end

    // Merge this cycle's columns into the partial result.
    always_comb begin
        res_next = res_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++)
            res_next = put_col(res_next, col_sel[g], col_out[g]);
    end

    // Controller FSM, column index and data registers.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        // NOTE: the data registers are reset too, so an aborted transform leaves no stale state visible.
        if (!pi_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            in_q    <= '0;
            res_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pi_start) begin
                        in_q    <= pi_in;
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_next;
                    idx_q <= idx_q + IDX_STEP;
                    if (idx_q == LAST_IDX) begin
                        out_q   <= res_next;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign po_busy = (state_q == BUSY);
    assign po_done = done_q;
    assign po_out  = out_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter against a GF(2^8) matrix model.
module tb_inv_mix_columns_iter;

    localparam int CPC = 1;
    localparam int LAT = 4 / CPC;
    localparam int BUDGET = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] din;
    logic         busy;
    logic         done;
    logic [127:0] dout;

    int n_checks = 0;
    int n_pass   = 0;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
        .pi_clk   (clk),
        .pi_rst_n (rst_n),
        .pi_start (start),
        .pi_in    (din),
        .po_busy  (busy),
        .po_done  (done),
        .po_out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------

    // Carry-less product followed by polynomial long division by 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix times each column; inverse selects {0e,0b,0d,09}, else {02,03,01,01}.
    function automatic logic [127:0] model_mix(input logic [127:0] st, input bit inverse);
        int         coef [4];
        logic [7:0] b [16];
        logic [7:0] acc;
        logic [127:0] r;
        if (inverse) coef = '{14, 11, 13, 9};
        else         coef = '{2, 3, 1, 1};
        for (int k = 0; k < 16; k++) b[k] = st[127-8*k -: 8];
        r = '0;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(b[4*((row + j) % 4) + col], 8'(coef[j]));
                r[127-8*(4*row+col) -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] pack_cols(input logic [31:0] c0, input logic [31:0] c1,
                                               input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cs [4];
        logic [127:0] r;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*row+c) -: 8] = cs[c][31-8*row -: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Start a transform (caller is just after an edge, DUT idle), scramble pi_in
    // after the start edge, and wait for done. lat = edges after the start edge, -1 on timeout.
    task automatic run_op(input logic [127:0] data, output logic [127:0] res, output int lat);
        start = 1'b1;
        din   = data;
        @(posedge clk); #1;
        start = 1'b0;
        din   = rand128();
        lat   = 0;
        while (!done && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        res = dout;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (dout !== 128'h0) $display("FAIL reset_out: got %h want 0", dout); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset: busy %b done %b want 0 0", busy, done); else n_pass++;
    endtask

    task automatic test_vector();
        logic [127:0] res, exp;
        int lat;
        exp = pack_cols(32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5);
        start = 1'b1;
        din   = pack_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6);
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL vec_busy_after_start: got %b want 1", busy); else n_pass++;
        lat = 0;
        while (!done && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        res = dout;
        n_checks++; if (lat !== LAT) $display("FAIL vec_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_checks++; if (res !== exp) $display("FAIL vec_result: got %h want %h", res, exp); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL vec_busy_at_done: got %b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL vec_done_width: got %b want 0", done); else n_pass++;
        n_checks++; if (dout !== exp) $display("FAIL vec_out_held: got %h want %h", dout, exp); else n_pass++;
    endtask

    task automatic test_fixed_points();
        logic [127:0] res;
        logic [127:0] pats [3];
        int lat;
        pats[0] = {16{8'h01}};
        pats[1] = {16{8'hc6}};
        pats[2] = '0;
        for (int i = 0; i < 3; i++) begin
            run_op(pats[i], res, lat);
            n_checks++; if (res !== pats[i]) $display("FAIL fixed_point_%0d: got %h want %h", i, res, pats[i]); else n_pass++;
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] st, res;
        int lat;
        int bad_lat = 0;
        for (int i = 0; i < 1000; i++) begin
            st = rand128();
            run_op(model_mix(st, 1'b0), res, lat);
            n_checks++; if (res !== st) $display("FAIL round_trip_%0d: got %h want %h", i, res, st); else n_pass++;
            if (lat != LAT) bad_lat++;
        end
        n_checks++; if (bad_lat !== 0) $display("FAIL round_trip_latency: got %0d bad latencies want 0", bad_lat); else n_pass++;
    endtask

    task automatic test_random_direct();
        logic [127:0] st, res, exp;
        int lat;
        for (int i = 0; i < 50; i++) begin
            st  = rand128();
            exp = model_mix(st, 1'b1);
            run_op(st, res, lat);
            n_checks++; if (res !== exp) $display("FAIL direct_%0d: got %h want %h", i, res, exp); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        int lat;
        a = rand128();
        b = rand128();
        start = 1'b1;
        din   = a;
        @(posedge clk); #1;
        start = 1'b0;
        din   = rand128();
        lat = 0;
        while (!done && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (done !== 1'b1 || dout !== model_mix(a, 1'b1)) $display("FAIL b2b_first: done %b got %h want %h", done, dout, model_mix(a, 1'b1)); else n_pass++;
        // pi_start high during the done cycle
        start = 1'b1;
        din   = b;
        @(posedge clk); #1;
        start = 1'b0;
        din   = rand128();
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy got %b want 1", busy); else n_pass++;
        lat = 0;
        while (!done && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        n_checks++; if (lat !== LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_checks++; if (dout !== model_mix(b, 1'b1)) $display("FAIL b2b_second: got %h want %h", dout, model_mix(b, 1'b1)); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        logic [127:0] a, exp;
        int n_done;
        a   = rand128();
        exp = model_mix(a, 1'b1);
        start = 1'b1;
        din   = a;
        @(posedge clk); #1;
        // pulse sampled on the edge after the start edge, while BUSY
        start = 1'b1;
        din   = rand128();
        @(posedge clk); #1;
        start = 1'b0;
        n_done = done ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            if (done && dout !== exp) $display("FAIL ignore_result: got %h want %h", dout, exp);
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_checks++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (dout !== exp) $display("FAIL ignore_out: got %h want %h", dout, exp); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ignore_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_latched_input();
        logic [127:0] x, a, prev, res;
        int lat;
        bit held_ok;
        x = rand128();
        run_op(x, res, lat);
        prev = model_mix(x, 1'b1);
        a = rand128();
        start = 1'b1;
        din   = a;
        @(posedge clk); #1;
        start   = 1'b0;
        held_ok = 1'b1;
        lat     = 0;
        while (!done && lat < BUDGET) begin
            if (dout !== prev) held_ok = 1'b0;
            din = ~a ^ rand128();
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (held_ok !== 1'b1) $display("FAIL out_held_during_op: got changed output want %h", prev); else n_pass++;
        n_checks++; if (dout !== model_mix(a, 1'b1)) $display("FAIL latched_input: got %h want %h", dout, model_mix(a, 1'b1)); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] c, res;
        int lat;
        int n_done;
        start = 1'b1;
        din   = rand128();
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        // idx is now 2 with one column per cycle; reset between clock edges
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midreset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (dout !== 128'h0) $display("FAIL midreset_out: got %h want 0", dout); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_checks++; if (n_done !== 0) $display("FAIL midreset_no_done: got %0d pulses want 0", n_done); else n_pass++;
        c = rand128();
        run_op(c, res, lat);
        n_checks++; if (lat !== LAT) $display("FAIL midreset_restart_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_checks++; if (res !== model_mix(c, 1'b1)) $display("FAIL midreset_restart: got %h want %h", res, model_mix(c, 1'b1)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vector();
        test_fixed_points();
        test_round_trip();
        test_random_direct();
        test_back_to_back();
        test_start_while_busy();
        test_latched_input();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
- Inverse MixColumns stage for the AES-128 decryption datapath; undoes the encryption-side column mixing.
- Multiplies each 32-bit state column by the inverse matrix {0e,0b,0d,09} (circulant) in GF(2^8), polynomial 0x11B.
- Iterative: processes COLS_PER_CYCLE columns per clock under a start/busy/done handshake.
- Sits between inverse ShiftRows/AddRoundKey stages in the decryption round controller.

Parameters:
COLS_PER_CYCLE, 1, number of columns computed per clock; legal values 1, 2, 4; other values are a elaboration error.

Ports:
pi_clk  input  1  clock, rising edge.
pi_rst_n  input  1  asynchronous active-low reset.
pi_start  input  1  request; sampled only in IDLE.
pi_in  input  128  state; row-major: byte k at [127-8k -: 8], row=k/4, col=k%4.
po_busy  output  1  high while a transform is in progress.
po_done  output  1  one-cycle pulse; po_out is valid from this cycle.
po_out  output  128  result; same row-major byte layout as pi_in.

Behaviour:
- Reset (pi_rst_n low, asynchronous): state IDLE, po_busy=0, po_done=0, po_out=0, column index=0, internal input/result registers=0.
- States: IDLE, BUSY.
- IDLE: pi_start=1 at edge N latches pi_in into the input register, sets column index 0, and goes BUSY. po_busy=1 from that edge.
- BUSY: each edge computes columns idx..idx+COLS_PER_CYCLE-1 from the latched input and writes them into the result register at their own row-major positions. idx then advances by COLS_PER_CYCLE.
- Completion: on the last column edge (N + 4/COLS_PER_CYCLE):
  - po_out is loaded with the complete result.
  - po_done=1 for exactly one cycle.
  - po_busy=0.
  - State returns to IDLE.
- Latency: start edge to done-visible = 4/COLS_PER_CYCLE edges (4, 2, 1).
- Throughput: back-to-back. A pi_start high in the cycle po_done is high is accepted, because the block is already in IDLE.
- pi_start while BUSY: ignored. No queuing, no error flag.
- pi_in may change freely after the start edge; only the latched copy is used.
- po_out holds the previous result during an operation and changes only at completion.
- Reset mid-operation: the operation is aborted and no po_done is generated. All outputs return to their reset values.
- Arithmetic:
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00).
  - 09·b = x3^b; 0b·b = x3^x1^b; 0d·b = x3^x2^b; 0e·b = x3^x2^x1, where xk = xtime applied k times.
  - Output row r of column c = 0e·s[r] ^ 0b·s[r+1] ^ 0d·s[r+2] ^ 09·s[r+3], with row indices mod 4.
- Index wrap: idx is 2 bits and returns to 0 after completion.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY = 8'h1B.
  - INV_MIX_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09}.
  - NUM_COLS = 4.
  - State typedefs IDLE/BUSY.
  - Helper functions xtime and gf_mul_const.
- One sub-module inv_calc_column: purely combinational, 32-bit column in, 32-bit column out.
  - Instantiated COLS_PER_CYCLE times.
  - Column select driven by idx.
- The top level holds the FSM, index counter, input/result registers and output registers.

Test Plan:
- Column vector: pi_in with column 0 = 8e,4d,a1,bc and columns 1-3 = 9f,dc,58,9d / 4d,7e,bd,f8 / d5,d5,d7,d6 -> po_out columns db,13,53,45 / f2,0a,22,5c / 2d,26,31,4c / d4,d4,d4,d5. po_done exactly 4 edges after start with COLS_PER_CYCLE=1, 2 edges with 2, 1 edge with 4.
- Fixed points: all bytes 01 -> all 01; all bytes c6 -> all c6; all zero -> all zero.
- Round trip: 1000 random states through a reference forward MixColumns model, then through the DUT -> po_out equals the original state every time.
- Back-to-back operation:
  - pi_start held high during the done cycle -> second operation accepted, no idle gap.
  - pi_start pulsed mid-BUSY -> ignored; exactly one po_done for that operation.
- pi_in changed after the start edge -> result depends only on the latched value.
- Reset mid-operation: pi_rst_n low at idx=2 -> po_busy, po_done and po_out are 0 immediately, asynchronously. No po_done after release. A new start then completes correctly.
